// File: rtl/tour_move_sequencer.sv
// Plays back the knight's-tour move table as vertical/horizontal drive legs, passing UART
// commands through while idle. Optional macro TOUR_FANFARE_EN: horizontal legs use opcode 4'h3.
`timescale 1ns/1ps
module tour_move_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] VERT  = 3'd1;
  localparam logic [2:0] WAITV = 3'd2;
  localparam logic [2:0] HORZ  = 3'd3;
  localparam logic [2:0] WAITH = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [3:0]       VERT_OP  = 4'h2;
`ifdef TOUR_FANFARE_EN
  localparam logic [3:0]       HORZ_OP  = 4'h3;
`else
  localparam logic [3:0]       HORZ_OP  = 4'h2;
`endif

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] indx_q, indx_d;

  logic [1:0]  dx_mag, dy_mag;
  logic        dx_pos, dy_pos;
  logic [15:0] vert_cmd, horz_cmd;

  // Lowest set bit of the one-hot move wins; an empty move decodes to a zero-length leg.
  always_comb begin
    dx_mag = 2'd0;
    dx_pos = 1'b0;
    dy_mag = 2'd0;
    dy_pos = 1'b0;
    casez (move)
      8'b???????1: begin dx_mag = 2'd1; dx_pos = 1'b0; dy_mag = 2'd2; dy_pos = 1'b1; end
      8'b??????10: begin dx_mag = 2'd1; dx_pos = 1'b1; dy_mag = 2'd2; dy_pos = 1'b1; end
      8'b?????100: begin dx_mag = 2'd2; dx_pos = 1'b0; dy_mag = 2'd1; dy_pos = 1'b1; end
      8'b????1000: begin dx_mag = 2'd2; dx_pos = 1'b0; dy_mag = 2'd1; dy_pos = 1'b0; end
      8'b???10000: begin dx_mag = 2'd1; dx_pos = 1'b0; dy_mag = 2'd2; dy_pos = 1'b0; end
      8'b??100000: begin dx_mag = 2'd1; dx_pos = 1'b1; dy_mag = 2'd2; dy_pos = 1'b0; end
      8'b?1000000: begin dx_mag = 2'd2; dx_pos = 1'b1; dy_mag = 2'd1; dy_pos = 1'b0; end
      8'b10000000: begin dx_mag = 2'd2; dx_pos = 1'b1; dy_mag = 2'd1; dy_pos = 1'b1; end
      default:     begin dx_mag = 2'd0; dx_pos = 1'b0; dy_mag = 2'd0; dy_pos = 1'b0; end
    endcase
  end

  assign vert_cmd = {VERT_OP, (dy_pos ? 8'h00 : 8'h7F), {2'b00, dy_mag}};
  assign horz_cmd = {HORZ_OP, (dx_pos ? 8'hBF : 8'h3F), {2'b00, dx_mag}};

  always_comb begin
    state_d          = state_q;
    indx_d           = indx_q;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        if (start_tour) begin
          indx_d  = '0;
          state_d = VERT;
        end
      end
      VERT: begin
        cmd     = vert_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAITV;
      end
      WAITV: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAITH;
      end
      WAITH: begin
        cmd = horz_cmd;
        // The last move leaves indx parked on the final index.
        if (send_resp) begin
          if (indx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            indx_d  = indx_q + IDX_W'(1);
            state_d = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      indx_q  <= '0;
    end else begin
      state_q <= state_d;
      indx_q  <= indx_d;
    end
  end

  assign indx      = indx_q;
  assign tour_busy = (state_q != IDLE);
  assign resp      = ((state_q == IDLE) || ((state_q == WAITH) && (indx_q == LAST_IDX)))
                     ? 8'hA5 : 8'h5A;

endmodule
